// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default reset/exception addresses and the PC step size.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FULL   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEF = 16'h0002;
  localparam logic [15:0] PC_INC         = 16'd2;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetched instruction and its PC.
// Load has priority over clear; data/PC hold their value after a clear so
// the decode-side outputs never glitch when the entry is consumed.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc2_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  // Buffer entry: capture on load, drop valid on clear, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc2_o   = pc_q + ADDR_W'(PC_INC);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and hands one buffered instruction at a time to decode.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating decode-stall
// cycle counter on port stall_cnt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc2,
  input  logic               dec_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               exception,
  input  logic               rti,
  input  logic               halt,
  output logic [ADDR_W-1:0]  epc,
  output logic               halted
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              kill_q, kill_d;
  logic              buf_load_s;
  logic              buf_clear_s;
  logic              buf_valid_s;
  logic              accept_s;

  assign accept_s = buf_valid_s & dec_ready;

  fetch_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load_s),
    .clear_i (buf_clear_s),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (buf_valid_s),
    .instr_o (instr),
    .pc_o    (instr_pc),
    .pc2_o   (instr_pc2)
  );

  // State, PC, EPC and kill-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      kill_q  <= kill_d;
    end
  end

  // Next-state logic: fetch handshake, buffer control and redirect priority.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    kill_d      = kill_q;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (kill_q) begin
            // Stale response from before a redirect: drop it and refetch.
            kill_d = 1'b0;
          end else begin
            buf_load_s = 1'b1;
            pc_d       = pc_q + ADDR_W'(PC_INC);
            state_d    = ST_FULL;
          end
        end else if (accept_s && (redirect || exception || rti)) begin
          // Only reachable once prefetch lets decode accept during a request.
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          buf_clear_s = 1'b1;
          state_d     = ST_REQ;
          if (halt) begin
            state_d = ST_HALTED;
          end else if (exception) begin
            epc_d = instr_pc2;
            pc_d  = EXC_VECTOR;
          end else if (rti) begin
            pc_d = epc_q;
          end else if (redirect) begin
            pc_d = redirect_pc;
          end else begin
            pc_d = pc_q;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = buf_valid_s;
  assign epc         = epc_q;
  assign halted      = (state_q == ST_HALTED);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where decode holds off a valid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (state_q == ST_HALTED) begin
      stall_cnt_q <= 16'd0;
    end else if (buf_valid_s && !dec_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
